// File: rtl/t07_fpu_muldiv_if.sv
// Request/response bundle between the FPU and the fixed-point mul/div responder.
interface t07_fpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             sign;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, op, inA, inB,
        input  busy, done, result, remainder, sign, overflow, div_by_zero
    );

    modport slave (
        input  start, op, inA, inB,
        output busy, done, result, remainder, sign, overflow, div_by_zero
    );
endinterface

// File: rtl/t07_fpu_muldiv.sv
// Multi-cycle signed fixed-point multiply/divide responder.
// Operates on magnitudes (shift-add multiply, restoring divide, one bit per
// clock) and applies the sign and saturation when the result is written.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// MUL    | shift-add multiply, WIDTH iterations
// DIV    | restoring divide, WIDTH+FRAC iterations (exits at once on /0)
// DONE   | one-cycle done pulse; a new start is accepted here as well
module t07_fpu_muldiv #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                clk,
    input  logic                rst,
    t07_fpu_muldiv_if.slave     bus
);
    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               sign_r;
    logic [2*WIDTH-1:0] prod;
    logic [QW-1:0]      quo;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   rem_out;
    logic               ovf_r;
    logic               dbz_r;

    logic               accept;
    logic [WIDTH-1:0]   in_a_mag;
    logic [WIDTH-1:0]   in_b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     div_rsh;
    logic [WIDTH:0]     div_diff;
    logic               div_qbit;
    logic [WIDTH-1:0]   rem_next;
    logic [QW-1:0]      quo_next;
    logic [WIDTH-1:0]   fin_mag;
    logic               fin_ovf;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   sat_val;
    logic [WIDTH-1:0]   div_rem_signed;
    logic [WIDTH-1:0]   dbz_rem;

    assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign in_a_mag = bus.inA[WIDTH-1] ? (~bus.inA + 1'b1) : bus.inA;
    assign in_b_mag = bus.inB[WIDTH-1] ? (~bus.inB + 1'b1) : bus.inB;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a zero divisor leaves DIV after a single cycle.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = bus.op ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (cnt == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DIV: begin
                if ((mag_b == '0) || (cnt == '0)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_n = bus.op ? S_DIV : S_MUL;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One iteration of each algorithm plus the final sign/saturation step.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        prod_next = {mul_sum, prod[WIDTH-1:1]};

        div_rsh   = {rem_r, quo[QW-1]};
        div_diff  = div_rsh - {1'b0, mag_b};
        div_qbit  = ~div_diff[WIDTH];
        rem_next  = div_qbit ? div_diff[WIDTH-1:0] : div_rsh[WIDTH-1:0];
        quo_next  = {quo[QW-2:0], div_qbit};

        fin_mag = quo_next[WIDTH-1:0];
        fin_ovf = (|quo_next[QW-1:WIDTH]) | quo_next[WIDTH-1];
        if (state == S_MUL) begin
            fin_mag = prod_next[WIDTH+FRAC-1:FRAC];
            fin_ovf = (|prod_next[2*WIDTH-1:WIDTH+FRAC]) | prod_next[WIDTH+FRAC-1];
        end

        sat_val = sign_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        if (fin_ovf) begin
            fin_res = sat_val;
        end else if (sign_r) begin
            fin_res = ~fin_mag + 1'b1;
        end else begin
            fin_res = fin_mag;
        end

        div_rem_signed = sign_a ? (~rem_next + 1'b1) : rem_next;
        // Rebuilding inA from its magnitude also covers the most negative value.
        dbz_rem        = sign_a ? (~mag_a + 1'b1) : mag_a;
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            sign_a   <= 1'b0;
            sign_r   <= 1'b0;
            prod     <= '0;
            quo      <= '0;
            rem_r    <= '0;
            result_r <= '0;
            rem_out  <= '0;
            ovf_r    <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (accept) begin
            mag_a  <= in_a_mag;
            mag_b  <= in_b_mag;
            sign_a <= bus.inA[WIDTH-1];
            sign_r <= bus.inA[WIDTH-1] ^ bus.inB[WIDTH-1];
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b0;
            prod   <= {{WIDTH{1'b0}}, in_b_mag};
            quo    <= {in_a_mag, {FRAC{1'b0}}};
            rem_r  <= '0;
            cnt    <= bus.op ? CW'(QW - 1) : CW'(WIDTH - 1);
        end else begin
            case (state)
                S_MUL: begin
                    prod <= prod_next;
                    if (cnt == '0) begin
                        result_r <= fin_res;
                        rem_out  <= '0;
                        ovf_r    <= fin_ovf;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    if (mag_b == '0) begin
                        dbz_r    <= 1'b1;
                        ovf_r    <= 1'b0;
                        result_r <= sat_val;
                        rem_out  <= dbz_rem;
                    end else begin
                        quo   <= quo_next;
                        rem_r <= rem_next;
                        if (cnt == '0) begin
                            result_r <= fin_res;
                            rem_out  <= div_rem_signed;
                            ovf_r    <= fin_ovf;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == S_MUL) || (state == S_DIV);
    assign bus.done        = (state == S_DONE);
    assign bus.result      = result_r;
    assign bus.remainder   = rem_out;
    assign bus.sign        = sign_r;
    assign bus.overflow    = ovf_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_t07_fpu_muldiv.sv
// Directed scoreboard bench for t07_fpu_muldiv (WIDTH=32, FRAC=16).
module tb_t07_fpu_muldiv;
    localparam int MUL_LAT = 33;
    localparam int DIV_LAT = 49;
    localparam int DBZ_LAT = 2;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [31:0] rem;
        logic        sgn;
        logic        ovf;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   fails;
    exp_t sb[$];

    t07_fpu_muldiv_if #(.WIDTH(32)) bus ();

    t07_fpu_muldiv #(.WIDTH(32), .FRAC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_result"}, bus.result, e.res);
                chk({e.nm, "_remainder"}, bus.remainder, e.rem);
                chk({e.nm, "_sign"}, {31'd0, bus.sign}, {31'd0, e.sgn});
                chk({e.nm, "_overflow"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
                chk({e.nm, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                chk({e.nm, "_done_cycle"}, cyc, e.done_cyc);
            end
        end
    end

    // Drive one request; returns the tb cycle count just after the accepting edge.
    task automatic issue(input string nm, input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [31:0] rem, input logic sgn,
                         input logic ovf, input logic dbz, input int lat, input bit push_it,
                         input bit hold, output int acc);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.inA   = a;
        bus.inB   = b;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) bus.start = 1'b0;
        if (push_it) begin
            e.nm = nm; e.res = res; e.rem = rem; e.sgn = sgn;
            e.ovf = ovf; e.dbz = dbz; e.done_cyc = acc + lat - 1;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({nm, "_result"}, bus.result, 32'd0);
        chk({nm, "_remainder"}, bus.remainder, 32'd0);
        chk({nm, "_sign"}, {31'd0, bus.sign}, 32'd0);
        chk({nm, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
        chk({nm, "_dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
    endtask

    initial begin
        int acc;
        int acc2;
        exp_t e;
        vectors = 0;
        fails   = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.inA   = '0;
        bus.inB   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1.5 * 2.0 with busy window checks
        issue("mul_1p5x2", 1'b0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        chk("mul_busy_c1", {31'd0, bus.busy}, 32'd1);
        chk("mul_done_c1", {31'd0, bus.done}, 32'd0);
        repeat (31) @(posedge clk);
        #1;
        chk("mul_busy_c32", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("mul_busy_c33", {31'd0, bus.busy}, 32'd0);
        drain(60);

        issue("mul_neg1p5x2", 1'b0, 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 32'h0, 1'b1, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        drain(60);
        issue("mul_ovf", 1'b0, 32'h4000_0000, 32'h0004_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        drain(60);
        issue("mul_minneg", 1'b0, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        drain(60);
        issue("mul_negzero", 1'b0, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        drain(60);
        issue("mul_trunc", 1'b0, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        drain(60);

        issue("div_third", 1'b1, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0001_0000, 1'b0, 1'b0, 1'b0,
              DIV_LAT, 1'b1, 1'b0, acc);
        drain(80);
        issue("div_neg3by2", 1'b1, 32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 32'h0, 1'b1, 1'b0, 1'b0,
              DIV_LAT, 1'b1, 1'b0, acc);
        drain(80);
        issue("div_negrem", 1'b1, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0,
              DIV_LAT, 1'b1, 1'b0, acc);
        drain(80);
        issue("div_ovf", 1'b1, 32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0,
              DIV_LAT, 1'b1, 1'b0, acc);
        drain(80);
        issue("div_by0", 1'b1, 32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0005_0000, 1'b0, 1'b0, 1'b1,
              DBZ_LAT, 1'b1, 1'b0, acc);
        drain(20);
        issue("div_by0_neg", 1'b1, 32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFB_0000, 1'b1, 1'b0, 1'b1,
              DBZ_LAT, 1'b1, 1'b0, acc);
        drain(20);

        // Start while busy must not disturb the running multiply.
        issue("mul_ignore", 1'b0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.inA   = 32'hFFFB_0000;
        bus.inB   = 32'h0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ignore_busy", {31'd0, bus.busy}, 32'd1);
        drain(60);

        // Reset in the middle of a divide, then a fresh op.
        issue("div_abort", 1'b1, 32'hFFFD_0000, 32'h0002_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
              DIV_LAT, 1'b0, 1'b0, acc);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        issue("mul_after_rst", 1'b0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b0, acc);
        drain(60);

        // Start held high: the second op is accepted in the DONE cycle of the first.
        issue("b2b_first", 1'b0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0,
              MUL_LAT, 1'b1, 1'b1, acc);
        acc2 = acc + MUL_LAT;
        e.nm = "b2b_second"; e.res = 32'hFFFD_0000; e.rem = 32'h0; e.sgn = 1'b1;
        e.ovf = 1'b0; e.dbz = 1'b0; e.done_cyc = acc2 + MUL_LAT - 1;
        sb.push_back(e);
        repeat (20) @(negedge clk);
        bus.inA = 32'hFFFE_8000;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        drain(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
